// File: rtl/imm_extend_pipe_if.sv
// imm_extend_pipe_if: producer/consumer handshake bundle for imm_extend_pipe.
// Ports: in_valid/in_ready/in_imm/in_mode, out_valid/out_ready/out_data, occupancy.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
);
    logic                         in_valid;
    logic                         in_ready;
    logic [IN_W-1:0]              in_imm;
    logic [1:0]                   in_mode;
    logic                         out_valid;
    logic                         out_ready;
    logic [OUT_W-1:0]             out_data;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extension (sign/zero/upper/branch)
// Ports: clk, reset (async active-low), bus (imm_extend_pipe_if.slave).
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    imm_extend_pipe_if.slave     bus
);
    localparam int E  = OUT_W - IN_W;
    localparam int OW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] last_q;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [OW-1:0]    occ_q, occ_d;

    logic [OUT_W-1:0] sext, zext, upper, branch, ext;
    logic             push, pop;

    always_comb begin
        sext   = {{E{bus.in_imm[IN_W-1]}}, bus.in_imm};
        zext   = {{E{1'b0}}, bus.in_imm};
        upper  = {bus.in_imm, {E{1'b0}}};
        branch = sext << SHIFT;
        ext    = sext;
        unique case (bus.in_mode)
            2'b00: ext = sext;
            2'b01: ext = zext;
            2'b10: ext = upper;
            2'b11: ext = branch;
            default: ext = sext;
        endcase
    end

    assign bus.in_ready  = occ_q < OW'(DEPTH);
    assign bus.out_valid = occ_q != '0;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // When empty, out_data shows the most recently popped value rather
    // than whatever stale slot the read pointer lands on.
    assign bus.out_data  = bus.out_valid ? mem_q[rptr_q] : last_q;
    assign bus.occupancy = occ_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            if (pop) begin
                last_q <= mem_q[rptr_q];
            end
            if (push) begin
                mem_q[wptr_q] <= ext;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for imm_extend_pipe
// Covers default params and an IN_W=12/OUT_W=16/SHIFT=1/DEPTH=4 instance.
module tb_imm_extend_pipe;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [31:0] qa[$];
    logic [15:0] qb[$];

    imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .DEPTH(2)) a ();
    imm_extend_pipe_if #(.IN_W(12), .OUT_W(16), .DEPTH(4)) b ();

    imm_extend_pipe #(
        .IN_W(16), .OUT_W(32), .SHIFT(2), .DEPTH(2)
    ) dut_a (
        .clk(clk), .reset(rst_n), .bus(a)
    );

    imm_extend_pipe #(
        .IN_W(12), .OUT_W(16), .SHIFT(1), .DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(rst_n), .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc_a(input logic v, input logic [15:0] imm,
                         input logic [1:0] md, input logic rdy,
                         input logic [31:0] exp);
        @(negedge clk);
        a.in_valid  = v;
        a.in_imm    = imm;
        a.in_mode   = md;
        a.out_ready = rdy;
        #1;
        chk("a_valid", 32'(a.out_valid), 32'(qa.size() != 0));
        chk("a_occ", 32'(a.occupancy), qa.size());
        chk("a_in_ready", 32'(a.in_ready), 32'(qa.size() < 2));
        if (a.out_valid && a.out_ready) begin
            if (qa.size() == 0) chk("a_unexpected", 1, 0);
            else chk("a_data", a.out_data, qa.pop_front());
        end
        if (a.in_valid && a.in_ready) qa.push_back(exp);
    endtask

    task automatic cyc_b(input logic v, input logic [11:0] imm,
                         input logic [1:0] md, input logic rdy,
                         input logic [15:0] exp);
        @(negedge clk);
        b.in_valid  = v;
        b.in_imm    = imm;
        b.in_mode   = md;
        b.out_ready = rdy;
        #1;
        chk("b_valid", 32'(b.out_valid), 32'(qb.size() != 0));
        chk("b_occ", 32'(b.occupancy), qb.size());
        chk("b_in_ready", 32'(b.in_ready), 32'(qb.size() < 4));
        if (b.out_valid && b.out_ready) begin
            if (qb.size() == 0) chk("b_unexpected", 1, 0);
            else chk("b_data", 32'(b.out_data), 32'(qb.pop_front()));
        end
        if (b.in_valid && b.in_ready) qb.push_back(exp);
    endtask

    task automatic drain_a();
        for (int i = 0; i < 10 && qa.size() > 0; i++)
            cyc_a(1'b0, 16'h0, 2'b00, 1'b1, 32'h0);
        chk("a_drain_left", qa.size(), 0);
        cyc_a(1'b0, 16'h0, 2'b00, 1'b1, 32'h0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 10 && qb.size() > 0; i++)
            cyc_b(1'b0, 12'h0, 2'b00, 1'b1, 16'h0);
        chk("b_drain_left", qb.size(), 0);
        cyc_b(1'b0, 12'h0, 2'b00, 1'b1, 16'h0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        a.in_valid  = 1'b0;
        a.in_imm    = '0;
        a.in_mode   = '0;
        a.out_ready = 1'b1;
        b.in_valid  = 1'b0;
        b.in_imm    = '0;
        b.in_mode   = '0;
        b.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a.out_valid), 0);
        chk("rst_occ", 32'(a.occupancy), 0);
        chk("rst_data", a.out_data, 0);
        chk("rst_in_ready", 32'(a.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // sign then zero extension, one-cycle latency
        cyc_a(1'b1, 16'hF000, 2'b00, 1'b1, 32'hFFFFF000);
        cyc_a(1'b1, 16'h0011, 2'b01, 1'b1, 32'h00000011);
        cyc_a(1'b1, 16'h8310, 2'b10, 1'b1, 32'h83100000);
        cyc_a(1'b1, 16'h9999, 2'b11, 1'b1, 32'hFFFE6664);
        drain_a();
        chk("a_empty_hold", a.out_data, 32'hFFFE6664);

        // backpressure: third push refused, head stable
        cyc_a(1'b1, 16'h0001, 2'b00, 1'b0, 32'h00000001);
        cyc_a(1'b1, 16'h8000, 2'b00, 1'b0, 32'hFFFF8000);
        cyc_a(1'b1, 16'h1234, 2'b00, 1'b0, 32'h00001234);
        chk("a_stall_head", a.out_data, 32'h00000001);
        cyc_a(1'b0, 16'h5555, 2'b11, 1'b0, 32'h0);
        chk("a_stall_head2", a.out_data, 32'h00000001);
        drain_a();

        // simultaneous push/pop at occupancy 1
        cyc_a(1'b1, 16'h0100, 2'b01, 1'b1, 32'h00000100);
        for (int i = 1; i <= 8; i++)
            cyc_a(1'b1, 16'(16'h0100 + i), 2'b01, 1'b1, 32'(32'h100 + i));
        drain_a();

        // async reset with occupancy 2
        cyc_a(1'b1, 16'h0AAA, 2'b00, 1'b0, 32'h00000AAA);
        cyc_a(1'b1, 16'h0BBB, 2'b00, 1'b0, 32'h00000BBB);
        cyc_a(1'b0, 16'h0, 2'b00, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(a.out_valid), 0);
        chk("arst_occ", 32'(a.occupancy), 0);
        chk("arst_data", a.out_data, 0);
        chk("arst_in_ready", 32'(a.in_ready), 1);
        qa.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cyc_a(1'b1, 16'h7777, 2'b01, 1'b1, 32'h00007777);
        drain_a();

        // swept parameter instance
        cyc_b(1'b1, 12'h800, 2'b00, 1'b1, 16'hF800);
        cyc_b(1'b1, 12'h800, 2'b01, 1'b1, 16'h0800);
        cyc_b(1'b1, 12'h800, 2'b10, 1'b1, 16'h8000);
        cyc_b(1'b1, 12'h800, 2'b11, 1'b1, 16'hF000);
        drain_b();
        for (int i = 0; i < 5; i++)
            cyc_b(1'b1, 12'(12'h010 + i), 2'b01, 1'b0, 16'(16'h010 + i));
        chk("b_full_ready", 32'(b.in_ready), 0);
        drain_b();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, registered immediate-extension stage for the datapath decode/execute boundary.
- Generalises plain 16->32 sign extension to configurable widths and four extension modes: sign, zero, upper-load and shifted branch offset.
- Results are held in a small parametrised output buffer with valid/ready handshakes on both sides, so a stalled consumer does not lose immediates.

Parameters:
- IN_W, 16, input immediate width; must be >= 1.
- OUT_W, 32, output width; must be > IN_W.
- SHIFT, 2, left-shift amount applied in branch mode; must be < OUT_W.
- DEPTH, 2, result buffer entries; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_imm and in_mode are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- in_imm  input  IN_W  raw immediate field.
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
- out_valid  output  1  out_data holds a valid result.
- out_ready  input  1  consumer takes out_data this cycle.
- out_data  output  OUT_W  extended result at the buffer head.
- occupancy  output  $clog2(DEPTH+1)  number of buffered results.

Behaviour:
- Extension function (combinational, applied on accept; E = OUT_W-IN_W):
  - Mode 00: {E copies of in_imm[IN_W-1], in_imm}.
  - Mode 01: {E zeros, in_imm}.
  - Mode 10: in_imm placed in the top IN_W bits, lower E bits zero. When IN_W > E, the result is truncated to OUT_W keeping the top bits.
  - Mode 11: the mode-00 result shifted left by SHIFT. Bits shifted past OUT_W-1 are discarded; SHIFT LSBs are zero.
- Handshake:
  - Push occurs on a clock edge when in_valid && in_ready.
  - Pop occurs on a clock edge when out_valid && out_ready.
  - in_ready = (occupancy < DEPTH). It is independent of out_ready; there is no full-buffer pass-through.
  - out_valid = (occupancy != 0).
  - out_data = head entry; it is stable while out_valid && !out_ready.
- Buffer: circular FIFO with write and read pointers.
  - Both pointers wrap from DEPTH-1 to 0.
  - FIFO order is preserved.
- Latency: an input accepted at edge k appears on out_data and out_valid after edge k. Minimum one cycle; no combinational input-to-output path.
- Simultaneous push and pop when 0 < occupancy < DEPTH:
  - Both happen.
  - occupancy is unchanged.
  - The head advances to the next entry.
- Full (occupancy == DEPTH): in_ready = 0, so in_valid is ignored. A pop that cycle frees a slot, and in_ready returns to 1 the following cycle.
- Empty: out_valid = 0. out_ready is ignored, and out_data holds its last value (0 after reset).
- in_mode and in_imm are sampled only on a push. Changes without a push have no effect.
- Reset (reset low, any time, asynchronous):
  - occupancy = 0, both pointers = 0, all storage = 0.
  - out_valid = 0, out_data = 0.
  - in_ready = 1 immediately after reset asserts.
  - Reset mid-transfer discards all buffered results.
  - The first push is allowed on the first rising edge after reset deasserts.
- Internal logic never drives X; every output is defined in all states.

Test Plan:
- Defaults, out_ready=1. Push 16'hF000 mode 00, then 16'h0011 mode 01 on consecutive cycles -> out_data 32'hFFFFF000 then 32'h00000011, one cycle after each push; occupancy stays <= 1.
- Push 16'h8310 mode 10 -> 32'h83100000. Push 16'h9999 mode 11 -> 32'hFFFE6664 (sign-extend, shift left 2, truncate).
- Backpressure, out_ready=0. Push 16'h0001, 16'h8000, 16'h1234 (all mode 00) -> after two pushes occupancy=2 and in_ready=0. The third push is refused. out_data holds 32'h00000001 stable. Release out_ready -> outputs 32'h00000001 then 32'hFFFF8000, in order.
- Simultaneous push/pop at occupancy 1 over 8 cycles with incrementing immediates -> occupancy remains 1, every value emerges exactly once and in order, and pointer wrap is exercised.
- Assert reset with occupancy=2 between clock edges -> out_valid=0, occupancy=0, out_data=0 and in_ready=1 without waiting for a clock edge. The next push after release emerges alone.
- Parameter sweep IN_W=12, OUT_W=16, SHIFT=1, DEPTH=4:
  - 12'h800 mode 00 -> 16'hF800.
  - 12'h800 mode 01 -> 16'h0800.
  - 12'h800 mode 10 -> 16'h8000 (truncated upper placement).
  - 12'h800 mode 11 -> 16'hF000.
  - Four pushes fill the buffer and in_ready drops.
